// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: parametrised scratch register file with one synchronous
// write port and two registered read ports. After reset the whole array
// is swept to zero one entry per cycle while busy is high. Reads forward
// same-cycle write data, and out-of-range accesses are flagged on err.
module reg_file_2r1w #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] in,
  input  logic          read_a,
  input  logic [AW-1:0] raddr_a,
  input  logic          read_b,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  output logic          valid_a,
  output logic          valid_b,
  output logic          err,
  output logic          busy
);

  // Pointer is one bit wider than an address so DEPTH == 2**AW is reachable.
  localparam logic [AW:0] LAST_PTR  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW:0]   r_clr_ptr;
  logic [AW:0]   w_clr_ptr_next;
  logic [DW-1:0] r_mem [DEPTH];
  logic          r_err;

  logic          w_ready;
  logic          w_wr_in_range;
  logic          w_wr_ok;
  logic          w_wr_oor;
  logic [1:0]    w_rd_en;
  logic [1:0]    w_rd_req;
  logic [1:0]    w_rd_oor;
  logic [AW-1:0] w_rd_addr [2];

  // Accesses are only honoured in READY and never in a reset cycle.
  assign w_ready       = (r_state == ST_READY) && !rst;
  assign w_wr_in_range = ({1'b0, waddr} < DEPTH_EXT);
  assign w_wr_ok       = w_ready && write && w_wr_in_range;
  assign w_wr_oor      = w_ready && write && !w_wr_in_range;

  assign w_rd_en[0]   = read_a;
  assign w_rd_en[1]   = read_b;
  assign w_rd_addr[0] = raddr_a;
  assign w_rd_addr[1] = raddr_b;

  // State and sweep pointer register; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_ptr <= w_clr_ptr_next;
    end
  end

  // Next-state logic: advance the sweep, leave CLEAR after the last entry.
  always_comb begin
    w_state_next   = r_state;
    w_clr_ptr_next = r_clr_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_clr_ptr_next = r_clr_ptr + (AW+1)'(1);
        if (r_clr_ptr == LAST_PTR) begin
          w_state_next = ST_READY;
        end
      end
      default: begin
        w_state_next = ST_READY;
      end
    endcase
  end

  // Single array write port: zeroes from the sweep, otherwise user writes.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr[AW-1:0]] <= '0;
    end else if (w_wr_ok) begin
      r_mem[waddr] <= in;
    end
  end

  // Both read ports are identical; forwarding gives write-first behaviour.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_port
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          w_in_range;

    assign w_in_range   = ({1'b0, w_rd_addr[gi]} < DEPTH_EXT);
    assign w_rd_req[gi] = w_ready && w_rd_en[gi];
    assign w_rd_oor[gi] = w_rd_req[gi] && !w_in_range;

    // Registered read: data holds when idle, valid pulses per accepted read.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_rd_req[gi];
        if (w_rd_req[gi]) begin
          if (!w_in_range) begin
            r_data <= '0;
          end else if (w_wr_ok && (w_rd_addr[gi] == waddr)) begin
            r_data <= in;
          end else begin
            r_data <= r_mem[w_rd_addr[gi]];
          end
        end
      end
    end
  end

  // Error pulse for any accepted out-of-range access this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_wr_oor || (|w_rd_oor);
    end
  end

  assign data_a  = gen_port[0].r_data;
  assign data_b  = gen_port[1].r_data;
  assign valid_a = gen_port[0].r_valid;
  assign valid_b = gen_port[1].r_valid;
  assign err     = r_err;
  assign busy    = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w: a full-depth instance (DEPTH=32) and a
// partial-depth instance (DEPTH=20) with scoreboarded read/err responses.
module tb_reg_file_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-depth instance signals
  logic       rst, write, read_a, read_b;
  logic [4:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata, data_a, data_b;
  logic       valid_a, valid_b, err, busy;

  // Partial-depth instance signals
  logic       rst_20, write_20, read_a_20, read_b_20;
  logic [4:0] waddr_20, raddr_a_20, raddr_b_20;
  logic [7:0] wdata_20, data_a_20, data_b_20;
  logic       valid_a_20, valid_b_20, err_20, busy_20;

  reg_file_2r1w #(.DW(8), .AW(5), .DEPTH(32)) u_dut (
    .clk(clk), .rst(rst), .write(write), .waddr(waddr), .in(wdata),
    .read_a(read_a), .raddr_a(raddr_a), .read_b(read_b), .raddr_b(raddr_b),
    .data_a(data_a), .data_b(data_b), .valid_a(valid_a), .valid_b(valid_b),
    .err(err), .busy(busy)
  );

  reg_file_2r1w #(.DW(8), .AW(5), .DEPTH(20)) u_dut20 (
    .clk(clk), .rst(rst_20), .write(write_20), .waddr(waddr_20), .in(wdata_20),
    .read_a(read_a_20), .raddr_a(raddr_a_20), .read_b(read_b_20), .raddr_b(raddr_b_20),
    .data_a(data_a_20), .data_b(data_b_20), .valid_a(valid_a_20), .valid_b(valid_b_20),
    .err(err_20), .busy(busy_20)
  );

  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_t;

  typedef struct {
    int   due;
    logic e;
  } er_t;

  rd_t qa[$];
  rd_t qb[$];
  rd_t qa20[$];
  er_t qe[$];
  er_t qe20[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents output.
  always @(negedge clk) begin
    rd_t r;
    er_t e;
    if (valid_a === 1'b1) begin
      if (qa.size() == 0) chk("rd_a unexpected valid", 32'(valid_a), 32'd0);
      else begin
        r = qa.pop_front();
        chk("rd_a cycle", 32'(cyc), 32'(r.due));
        chk("rd_a data", 32'(data_a), 32'(r.data));
        $display("rd_a  cyc=%0d data=%02h exp=%02h", cyc, data_a, r.data);
      end
    end else if (qa.size() > 0 && qa[0].due <= cyc) begin
      r = qa.pop_front();
      chk("rd_a missing valid", 32'(valid_a), 32'd1);
    end
    if (valid_b === 1'b1) begin
      if (qb.size() == 0) chk("rd_b unexpected valid", 32'(valid_b), 32'd0);
      else begin
        r = qb.pop_front();
        chk("rd_b cycle", 32'(cyc), 32'(r.due));
        chk("rd_b data", 32'(data_b), 32'(r.data));
        $display("rd_b  cyc=%0d data=%02h exp=%02h", cyc, data_b, r.data);
      end
    end else if (qb.size() > 0 && qb[0].due <= cyc) begin
      r = qb.pop_front();
      chk("rd_b missing valid", 32'(valid_b), 32'd1);
    end
    if (valid_a_20 === 1'b1) begin
      if (qa20.size() == 0) chk("rd20 unexpected valid", 32'(valid_a_20), 32'd0);
      else begin
        r = qa20.pop_front();
        chk("rd20 cycle", 32'(cyc), 32'(r.due));
        chk("rd20 data", 32'(data_a_20), 32'(r.data));
        $display("rd20  cyc=%0d data=%02h exp=%02h", cyc, data_a_20, r.data);
      end
    end else if (qa20.size() > 0 && qa20[0].due <= cyc) begin
      r = qa20.pop_front();
      chk("rd20 missing valid", 32'(valid_a_20), 32'd1);
    end
    if (valid_b_20 === 1'b1) chk("rd20_b unexpected valid", 32'(valid_b_20), 32'd0);
    if (qe.size() > 0 && qe[0].due <= cyc) begin
      e = qe.pop_front();
      chk("err32", 32'(err), 32'(e.e));
    end
    if (qe20.size() > 0 && qe20[0].due <= cyc) begin
      e = qe20.pop_front();
      chk("err20", 32'(err_20), 32'(e.e));
    end
  end

  task automatic idle();
    write = 1'b0; waddr = 5'd0; wdata = 8'h00;
    read_a = 1'b0; raddr_a = 5'd0; read_b = 1'b0; raddr_b = 5'd0;
  endtask

  task automatic idle20();
    write_20 = 1'b0; waddr_20 = 5'd0; wdata_20 = 8'h00;
    read_a_20 = 1'b0; raddr_a_20 = 5'd0; read_b_20 = 1'b0; raddr_b_20 = 5'd0;
  endtask

  // One READY-cycle transaction on the full-depth instance.
  task automatic op32(input logic w, input logic [4:0] wa, input logic [7:0] wd,
                      input logic ra, input logic [4:0] aa, input logic [7:0] ea,
                      input logic rb, input logic [4:0] ab, input logic [7:0] eb);
    write = w; waddr = wa; wdata = wd;
    read_a = ra; raddr_a = aa; read_b = rb; raddr_b = ab;
    if (ra) qa.push_back('{due: cyc + 1, data: ea});
    if (rb) qb.push_back('{due: cyc + 1, data: eb});
    qe.push_back('{due: cyc + 1, e: 1'b0});
    @(negedge clk);
    idle();
  endtask

  // One READY-cycle transaction on the partial-depth instance.
  task automatic op20(input logic w, input logic [4:0] wa, input logic [7:0] wd,
                      input logic ra, input logic [4:0] aa, input logic [7:0] ea,
                      input logic ee);
    write_20 = w; waddr_20 = wa; wdata_20 = wd;
    read_a_20 = ra; raddr_a_20 = aa;
    if (ra) qa20.push_back('{due: cyc + 1, data: ea});
    qe20.push_back('{due: cyc + 1, e: ee});
    @(negedge clk);
    idle20();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n32;
    int n20;
    int guard;
    logic [7:0] exp20;
    idle(); idle20();
    rst = 1'b0; rst_20 = 1'b0;
    @(negedge clk);
    rst = 1'b1; rst_20 = 1'b1;
    @(negedge clk);
    rst = 1'b0; rst_20 = 1'b0;

    // Reset values
    chk("reset data_a", 32'(data_a), 32'h0);
    chk("reset data_b", 32'(data_b), 32'h0);
    chk("reset valid_a", 32'(valid_a), 32'h0);
    chk("reset valid_b", 32'(valid_b), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset busy", 32'(busy), 32'h1);
    chk("reset busy20", 32'(busy_20), 32'h1);
    chk("reset err20", 32'(err_20), 32'h0);

    // Sweep: accesses during busy must be ignored
    write = 1'b1; waddr = 5'd5; wdata = 8'h99;
    read_a = 1'b1; raddr_a = 5'd0; read_b = 1'b1; raddr_b = 5'd31;
    n32 = 0; n20 = 0; guard = 0;
    while ((busy === 1'b1 || busy_20 === 1'b1) && guard < 200) begin
      if (busy === 1'b1) n32++;
      if (busy_20 === 1'b1) n20++;
      guard++;
      @(negedge clk);
    end
    idle();
    chk("sweep32 busy cycles", 32'(n32), 32'd32);
    chk("sweep20 busy cycles", 32'(n20), 32'd20);
    $display("sweep busy32=%0d busy20=%0d", n32, n20);

    // Every address reads zero after the sweep
    for (int i = 0; i < 32; i++)
      op32(1'b0, 5'd0, 8'h00, 1'b1, 5'(i), 8'h00, 1'b1, 5'(31 - i), 8'h00);

    // Basic write then read; neighbour stays zero
    op32(1'b1, 5'd3, 8'hA5, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
    op32(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 8'hA5, 1'b1, 5'd4, 8'h00);

    // Forwarding to both ports
    op32(1'b1, 5'd7, 8'h3C, 1'b1, 5'd7, 8'h3C, 1'b1, 5'd7, 8'h3C);

    // Top address, and write/read to different addresses in one cycle
    op32(1'b1, 5'd31, 8'h11, 1'b1, 5'd7, 8'h3C, 1'b0, 5'd0, 8'h00);
    op32(1'b1, 5'd8, 8'hC3, 1'b1, 5'd3, 8'hA5, 1'b1, 5'd31, 8'h11);
    op32(1'b0, 5'd0, 8'h00, 1'b1, 5'd8, 8'hC3, 1'b1, 5'd0, 8'h00);

    // Hold: data_a keeps 5A with valid_a low for three idle cycles
    op32(1'b1, 5'd10, 8'h5A, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
    op32(1'b0, 5'd0, 8'h00, 1'b1, 5'd10, 8'h5A, 1'b0, 5'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold data_a", 32'(data_a), 32'h5A);
      chk("hold valid_a", 32'(valid_a), 32'h0);
      $display("hold  cyc=%0d data_a=%02h valid_a=%0b", cyc, data_a, valid_a);
    end

    // Reset in READY, then a second reset ten cycles into the sweep
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("first sweep busy", 32'(busy), 32'h1);
      @(negedge clk);
    end
    rst = 1'b1;
    write = 1'b1; waddr = 5'd0; wdata = 8'hEE;
    read_a = 1'b1; raddr_a = 5'd3;
    @(negedge clk);
    rst = 1'b0;
    chk("restart data_a", 32'(data_a), 32'h0);
    n32 = 0; guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      n32++;
      guard++;
      @(negedge clk);
    end
    idle();
    chk("restart busy cycles", 32'(n32), 32'd32);
    $display("restart busy32=%0d", n32);
    op32(1'b0, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b1, 5'd3, 8'h00);
    op32(1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 8'h00, 1'b1, 5'd10, 8'h00);
    op32(1'b0, 5'd0, 8'h00, 1'b1, 5'd31, 8'h00, 1'b1, 5'd8, 8'h00);

    // Partial-depth instance: in-range boundary writes, out-of-range accesses
    op20(1'b1, 5'd0, 8'h24, 1'b0, 5'd0, 8'h00, 1'b0);
    op20(1'b1, 5'd19, 8'h42, 1'b0, 5'd0, 8'h00, 1'b0);
    op20(1'b1, 5'd25, 8'hFF, 1'b0, 5'd0, 8'h00, 1'b1);
    op20(1'b0, 5'd0, 8'h00, 1'b1, 5'd25, 8'h00, 1'b1);
    op20(1'b1, 5'd20, 8'hEE, 1'b1, 5'd19, 8'h42, 1'b1);
    op20(1'b1, 5'd5, 8'h77, 1'b1, 5'd31, 8'h00, 1'b1);
    op20(1'b0, 5'd0, 8'h00, 1'b1, 5'd20, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      exp20 = (i == 0) ? 8'h24 : (i == 19) ? 8'h42 : (i == 5) ? 8'h77 : 8'h00;
      op20(1'b0, 5'd0, 8'h00, 1'b1, 5'(i), exp20, 1'b0);
    end

    // Drain and confirm every expected response was seen
    repeat (3) @(negedge clk);
    chk("qa drained", 32'(qa.size()), 32'd0);
    chk("qb drained", 32'(qb.size()), 32'd0);
    chk("qa20 drained", 32'(qa20.size()), 32'd0);
    chk("qe drained", 32'(qe.size() + qe20.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
